// File: rtl/narnet_engine.sv
`default_nettype none
// ==== narnet_engine : NAR-network inference engine (tap-delay history, tanh hidden layer, linear output) on one shared MAC ====
// Revision: 1.0
module narnet_engine #(
    parameter int          N      = 16,
    parameter int          Q      = 10,
    parameter int          D      = 16,
    parameter int          H      = 8,
    parameter int          AW     = 12,
    parameter logic [N-1:0] INIT_X = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  x_in,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic          closed_loop,
    output logic [AW-1:0] w_addr,
    input  logic [N-1:0]  w_data,
    output logic [N-1:0]  t_addr,
    input  logic [N-1:0]  t_data,
    output logic [N-1:0]  y_out,
    output logic          y_valid
);

    localparam int PW      = $clog2(D);
    localparam int HW      = (H > 1) ? $clog2(H) : 1;
    localparam int KMAX    = (D > H) ? D : H;
    localparam int KW      = $clog2(KMAX + 1);
    localparam int GW      = (D > H) ? $clog2(D + 1) : $clog2(H + 1);
    localparam int ACC_W   = 2 * N + GW + 1;
    localparam int IW_BASE = H;
    localparam int LW_BASE = H + H * D;
    localparam int B2_ADDR = H + H * D + H;

    localparam logic signed [ACC_W-1:0] C_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HID_BIAS = 3'd1,
        S_HID_MAC  = 3'd2,
        S_HID_TANH = 3'd3,
        S_OUT_BIAS = 3'd4,
        S_OUT_MAC  = 3'd5,
        S_OUT_SAT  = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            wp_q, wp_d;
    logic [PW-1:0]            rp_q, rp_d;
    logic [HW-1:0]            h_q, h_d;
    logic [KW-1:0]            k_q, k_d;
    logic                     ph_q, ph_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [N-1:0]             t_addr_q, t_addr_d;
    logic [N-1:0]             y_q, y_d;
    logic [N-1:0]             hist_q [D];
    logic [N-1:0]             hid_q  [H];
    logic                     hist_we, hid_we;

    logic [N-1:0]             w_sample;
    logic [N-1:0]             w_opnd;
    logic signed [2*N-1:0]    w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic [N-1:0]             w_sat;
    logic [PW-1:0]            w_newest;
    logic [PW-1:0]            w_rp_dec;

    function automatic logic [N-1:0] sat_n(input logic signed [ACC_W-1:0] v);
        if (v > C_MAX)
            return {1'b0, {(N-1){1'b1}}};
        else if (v < C_MIN)
            return {1'b1, {(N-1){1'b0}}};
        else
            return v[N-1:0];
    endfunction

    // Closed-loop mode feeds the previous prediction back as the new sample.
    assign w_sample   = closed_loop ? y_q : x_in;
    assign w_opnd     = (state_q == S_OUT_MAC) ? hid_q[HW'(k_q - KW'(1))] : hist_q[rp_q];
    assign w_prod     = $signed(w_data) * $signed(w_opnd);
    assign w_prod_ext = {{(ACC_W-2*N){w_prod[2*N-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-N-Q){w_data[N-1]}}, w_data, {Q{1'b0}}};
    assign w_sat      = sat_n(acc_q >>> Q);
    assign w_newest   = (wp_q == '0) ? PW'(D - 1) : wp_q - PW'(1);
    assign w_rp_dec   = (rp_q == '0) ? PW'(D - 1) : rp_q - PW'(1);

    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        h_d      = h_q;
        k_d      = k_q;
        ph_d     = ph_q;
        acc_d    = acc_q;
        t_addr_d = t_addr_q;
        y_d      = y_q;
        hist_we  = 1'b0;
        hid_we   = 1'b0;
        w_addr   = '0;
        t_addr   = t_addr_q;
        y_out    = y_q;
        y_valid  = 1'b0;
        x_ready  = (state_q == S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (x_valid) begin
                    hist_we = 1'b1;
                    wp_d    = (wp_q == PW'(D - 1)) ? '0 : wp_q + PW'(1);
                    h_d     = '0;
                    state_d = S_HID_BIAS;
                end
            end
            S_HID_BIAS: begin
                w_addr  = AW'(h_q);
                rp_d    = w_newest;
                k_d     = '0;
                state_d = S_HID_MAC;
            end
            S_HID_MAC: begin
                // ROM word fetched last cycle is consumed this cycle; the read pointer walks newest to oldest.
                if (k_q < KW'(D))
                    w_addr = AW'(IW_BASE + int'(h_q) * D + int'(k_q));
                if (k_q == '0) begin
                    acc_d = w_bias_ext;
                end else begin
                    acc_d = acc_q + w_prod_ext;
                    rp_d  = w_rp_dec;
                end
                if (k_q == KW'(D)) begin
                    ph_d    = 1'b0;
                    state_d = S_HID_TANH;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_HID_TANH: begin
                if (!ph_q) begin
                    t_addr   = w_sat;
                    t_addr_d = w_sat;
                    ph_d     = 1'b1;
                end else begin
                    hid_we = 1'b1;
                    if (h_q == HW'(H - 1)) begin
                        state_d = S_OUT_BIAS;
                    end else begin
                        h_d     = h_q + HW'(1);
                        state_d = S_HID_BIAS;
                    end
                end
            end
            S_OUT_BIAS: begin
                w_addr  = AW'(B2_ADDR);
                k_d     = '0;
                state_d = S_OUT_MAC;
            end
            S_OUT_MAC: begin
                if (k_q < KW'(H))
                    w_addr = AW'(LW_BASE + int'(k_q));
                if (k_q == '0)
                    acc_d = w_bias_ext;
                else
                    acc_d = acc_q + w_prod_ext;
                if (k_q == KW'(H))
                    state_d = S_OUT_SAT;
                else
                    k_d = k_q + KW'(1);
            end
            S_OUT_SAT: begin
                y_out   = w_sat;
                y_d     = w_sat;
                y_valid = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wp_q     <= '0;
            rp_q     <= '0;
            h_q      <= '0;
            k_q      <= '0;
            ph_q     <= 1'b0;
            acc_q    <= '0;
            t_addr_q <= '0;
            y_q      <= '0;
            for (int i = 0; i < D; i++) hist_q[i] <= INIT_X;
            for (int i = 0; i < H; i++) hid_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            h_q      <= h_d;
            k_q      <= k_d;
            ph_q     <= ph_d;
            acc_q    <= acc_d;
            t_addr_q <= t_addr_d;
            y_q      <= y_d;
            if (hist_we) hist_q[wp_q] <= w_sample;
            if (hid_we)  hid_q[h_q]   <= t_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_narnet_engine.sv
`default_nettype none
// ==== tb_narnet_engine : directed bench for narnet_engine with weight ROM and identity tanh LUT models ====
// Revision: 1.0
module tb_narnet_engine;

    localparam int N       = 16;
    localparam int Q       = 10;
    localparam int D       = 16;
    localparam int H       = 8;
    localparam int AW      = 12;
    localparam int LAT     = H * (D + 4) + H + 3;
    localparam int IW_BASE = H;
    localparam int LW_BASE = H + H * D;
    localparam int B2_ADDR = H + H * D + H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  x_in = '0;
    logic          x_valid = 1'b0;
    logic          x_ready;
    logic          closed_loop = 1'b0;
    logic [AW-1:0] w_addr;
    logic [N-1:0]  w_data = '0;
    logic [N-1:0]  t_addr;
    logic [N-1:0]  t_data = '0;
    logic [N-1:0]  y_out;
    logic          y_valid;

    logic [N-1:0]  rom [1 << AW];

    int errors = 0;
    int checks = 0;

    narnet_engine #(.N(N), .Q(Q), .D(D), .H(H), .AW(AW), .INIT_X(16'h0000)) dut (
        .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
        .closed_loop(closed_loop), .w_addr(w_addr), .w_data(w_data),
        .t_addr(t_addr), .t_data(t_data), .y_out(y_out), .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    // Synchronous weight ROM and identity tanh LUT, both one-cycle latency.
    always @(posedge clk) begin
        w_data <= rom[w_addr];
        t_data <= t_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < (1 << AW); i++) rom[i] = '0;
    endtask

    // One request; watches the whole step and returns what it saw.
    task automatic run_step(input logic [N-1:0] xs, input logic cl,
                            output int vcyc, output logic [N-1:0] yv, output int nval,
                            output int bad, output logic [N-1:0] t19, output logic tneg);
        vcyc = -1; yv = '0; nval = 0; bad = 0; t19 = '0; tneg = 1'b0;
        @(negedge clk);
        x_in = xs; closed_loop = cl; x_valid = 1'b1;
        @(negedge clk);
        x_valid = 1'b0; x_in = 16'hDEAD; closed_loop = 1'b0;
        for (int c = 1; c <= LAT + 1; c++) begin
            if (c > 1) @(negedge clk);
            if (y_valid) begin nval++; vcyc = c; yv = y_out; end
            if (c <= LAT && x_ready) bad++;
            if (c == LAT + 1 && !x_ready) bad++;
            if (c == D + 3) t19 = t_addr;
            if (t_addr[N-1]) tneg = 1'b1;
        end
    endtask

    task automatic step_chk(input string tag, input logic [N-1:0] xs, input logic cl,
                            input logic [N-1:0] exp_y, output logic [N-1:0] t19, output logic tneg);
        int vcyc, nval, bad;
        logic [N-1:0] yv;
        run_step(xs, cl, vcyc, yv, nval, bad, t19, tneg);
        chk({tag, "_nvalid"}, 32'(nval), 32'd1);
        chk({tag, "_lat"}, 32'(vcyc), 32'(LAT));
        chk({tag, "_busy"}, 32'(bad), 32'd0);
        chk({tag, "_y"}, 32'(yv), 32'(exp_y));
    endtask

    initial begin
        int nv, first, second, third;
        logic [N-1:0] t19;
        logic tneg, tneg_acc;
        logic [N-1:0] ex;

        clear_rom();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_x_ready", 32'(x_ready), 32'd1);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y_out", 32'(y_out), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_t_addr", 32'(t_addr), 32'd0);

        // Latency and bias path: only b2 = 1.0.
        rom[B2_ADDR] = 16'd1024;
        step_chk("lat", 16'h0123, 1'b0, 16'd1024, t19, tneg);

        // Reset asserted for three cycles mid-computation.
        @(negedge clk);
        x_in = 16'h0400; x_valid = 1'b1;
        @(negedge clk);
        x_valid = 1'b0;
        nv = 0;
        for (int c = 2; c <= 250; c++) begin
            @(negedge clk);
            if (c == 49) chk("mid_hold_y", 32'(y_out), 32'd1024);
            if (c == 50) rst = 1'b1;
            if (c == 53) begin
                rst = 1'b0;
                chk("mid_x_ready", 32'(x_ready), 32'd1);
                chk("mid_y_out", 32'(y_out), 32'd0);
                chk("mid_w_addr", 32'(w_addr), 32'd0);
                chk("mid_t_addr", 32'(t_addr), 32'd0);
            end
            if (y_valid) nv++;
        end
        chk("mid_no_valid", 32'(nv), 32'd0);

        // Reset coincident with a request: nothing may be accepted.
        @(negedge clk);
        rst = 1'b1; x_valid = 1'b1; x_in = 16'h1234;
        @(negedge clk);
        rst = 1'b0; x_valid = 1'b0;
        @(negedge clk);
        chk("rstxv_x_ready", 32'(x_ready), 32'd1);
        chk("rstxv_w_addr", 32'(w_addr), 32'd0);

        // Tap order and ring wrap: y follows the oldest tap through an identity path.
        clear_rom();
        rom[IW_BASE + D - 1] = 16'd1024;
        rom[LW_BASE]         = 16'd1024;
        for (int k = 1; k <= D + 2; k++) begin
            ex = (k <= D - 1) ? 16'h0000 : N'((k - (D - 1)) * 128);
            step_chk($sformatf("tap%0d", k), N'(k * 128), 1'b0, ex, t19, tneg);
        end

        // Positive saturation of pre-activation and output.
        clear_rom();
        for (int d = 0; d < D; d++) rom[IW_BASE + d] = 16'h7FFF;
        rom[LW_BASE] = 16'h7FFF;
        tneg_acc = 1'b0;
        for (int k = 1; k < D; k++) begin
            step_chk($sformatf("satfill%0d", k), 16'h7FFF, 1'b0, 16'h7FFF, t19, tneg);
            tneg_acc = tneg_acc | tneg;
        end
        step_chk("satpos", 16'h7FFF, 1'b0, 16'h7FFF, t19, tneg);
        tneg_acc = tneg_acc | tneg;
        chk("satpos_t_addr", 32'(t19), 32'h7FFF);
        chk("satpos_t_nonneg", 32'(tneg_acc), 32'd0);

        rom[LW_BASE] = 16'h8001;
        step_chk("satneg_out", 16'h7FFF, 1'b0, 16'h8000, t19, tneg);

        for (int d = 0; d < D; d++) rom[IW_BASE + d] = 16'h8001;
        step_chk("satneg_both", 16'h7FFF, 1'b0, 16'h7FFF, t19, tneg);
        chk("satneg_t_addr", 32'(t19), 32'h8000);

        // Closed loop: y = b2 + newest tap; fed-back samples ignore x_in.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_rom();
        rom[IW_BASE] = 16'd1024;
        rom[LW_BASE] = 16'd1024;
        rom[B2_ADDR] = 16'd256;
        step_chk("cl_open", 16'd256, 1'b0, 16'd512, t19, tneg);
        step_chk("cl_1", 16'hDEAD, 1'b1, 16'd768, t19, tneg);
        step_chk("cl_2", 16'hDEAD, 1'b1, 16'd1024, t19, tneg);
        step_chk("cl_3", 16'hDEAD, 1'b1, 16'd1280, t19, tneg);

        // x_valid held high: one result per minimum request spacing.
        @(negedge clk);
        x_valid = 1'b1; x_in = 16'h0100; closed_loop = 1'b0;
        nv = 0; first = -1; second = -1; third = -1;
        for (int c = 0; c < 3 * (LAT + 1); c++) begin
            if (c > 0) @(negedge clk);
            if (y_valid) begin
                nv++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
                else third = c;
            end
        end
        x_valid = 1'b0;
        chk("busy_count", 32'(nv), 32'd3);
        chk("busy_first", 32'(first), 32'(LAT));
        chk("busy_gap1", 32'(second - first), 32'(LAT + 1));
        chk("busy_gap2", 32'(third - second), 32'(LAT + 1));
        repeat (2) @(negedge clk);
        chk("busy_idle", 32'(x_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/narnet_engine.md
# narnet_engine

Parametrised NAR-network inference engine: one scalar input sample per request, a D-deep tap-delay history, H tanh hidden neurons, one linear output neuron. It uses a single time-multiplexed multiply-accumulate unit. Weights come from an external synchronous ROM and tanh values from an external synchronous LUT. It is the generic successor to the fixed 16-delay/5-neuron engine: configurable depth, width and neuron count, saturating arithmetic, and a closed-loop (free-running prediction) mode.

## Interface
- N, 16: sample/weight width, signed two's complement
- Q, 10: fractional bits
- D, 16: tap-delay depth (≥2)
- H, 8: hidden neuron count (≥1)
- AW, 12: weight ROM address width; must satisfy H*D+2H+1 ≤ 2^AW
- INIT_X, 0: history value loaded at reset (N-bit)
- clk in 1: clock
- rst in 1: reset, synchronous, active-high; clock clk
- x_in in N: input sample
- x_valid in 1: request to process one step
- x_ready out 1: high only in IDLE
- closed_loop in 1: sampled at accept; 1 = feed back last y_out instead of x_in
- w_addr out AW: weight ROM address; data returned one cycle later
- w_data in N: weight ROM data
- t_addr out N: tanh LUT address (saturated pre-activation)
- t_data in N: tanh LUT data, one-cycle latency
- y_out out N: result, held until next result
- y_valid out 1: one-cycle pulse with each new y_out

## Operation
- ROM map:
  - b1[h] at h
  - IW[h][d] at H + h*D + d
  - LW[h] at H + H*D + h
  - b2 at H + H*D + H
- History: D-entry ring, write pointer wp. Tap d=0 is the newest sample; d=D-1 is the oldest.
- States: IDLE → HID_BIAS → HID_MAC → HID_TANH → (next h or OUT_BIAS) → OUT_MAC → OUT_SAT → IDLE.
- Accept on x_valid && x_ready. Sample s = closed_loop ? y_out : x_in. Write s at wp, then wp = (wp+1) mod D. The new sample is tap 0 for this step.
- Hidden neuron h:
  - acc = b1[h] << Q, then add IW[h][d]*tap[d] for d = 0..D-1.
  - Each product is a full 2N-bit value.
  - acc width is 2N + clog2(D+1) + 1.
  - pre = acc >>> Q (arithmetic), saturated to N-bit signed range.
  - t_addr = pre; hid[h] = t_data.
- Output: acc = b2 << Q plus the sum over h of LW[h]*hid[h]. y_out = sat_N(acc >>> Q).
- Saturation clamps to 2^(N-1)-1 / -2^(N-1); no wrap.
- x_valid outside IDLE is ignored. Nothing is queued and there is no error.

## Timing
- Accept cycle is cycle 0. Hidden neuron h occupies D+4 cycles starting at cycle 1 + h*(D+4):
  - +0: w_addr = b1[h]
  - +1 .. +D: w_addr = IW[h][d-1], and the previously returned word is accumulated
  - +D+1: last product accumulated
  - +D+2: t_addr driven
  - +D+3: hid[h] captured
- Output layer starts at cycle 1 + H*(D+4) and takes H+3 cycles: bias fetch, H weight fetches, final accumulate, saturate/register.
- y_valid is high exactly at cycle H*(D+4)+H+3; y_out updates in the same cycle. Default parameters: cycle 171.
- x_ready returns high the cycle after y_valid. Minimum request spacing is H*(D+4)+H+4 cycles.
- Reset values:
  - x_ready=1, y_valid=0, y_out=0
  - w_addr=0, t_addr=0
  - wp=0, all history=INIT_X, state IDLE
- rst mid-computation aborts: no y_valid, history restored to INIT_X. A sample written before the abort is lost.
- rst together with x_valid: reset wins, nothing is accepted.
- wp wraps from D-1 to 0. After D+1 accepts the oldest sample is overwritten.

## Test plan
- Reset: assert rst 3 cycles mid-run (cycle 50) → no y_valid; then x_ready=1, y_out=0, history=INIT_X.
- Latency and bias: all weights 0, b2=1.0 (1<<Q), D=16, H=8 → y_valid exactly at cycle 171 with y_out=1024; x_ready low during cycles 1..171.
- Tap order/wrap:
  - ROM: identity tanh LUT, IW[0][D-1]=1.0, LW[0]=1.0, all else 0.
  - Feed x = 1..D+2 (×1/8).
  - Expected: y equals INIT_X for the first D-1 steps, then the sample accepted D-1 steps earlier.
- Saturation: tap values 0x7FFF with IW=0x7FFF → t_addr=0x7FFF, never negative. LW=0x7FFF with hid=0x7FFF gives y_out=0x7FFF; the negated case gives 0x8000.
- Closed loop: after one open-loop step producing y=0.5, the next three steps with closed_loop=1 and x_in=0xDEAD write 0.5, then each successive y, into history; x_in has no effect.
- Busy: x_valid held high continuously → exactly one y_valid per H*(D+4)+H+4 cycles, with no extra accepts.
